// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: 32-cycle shift-add multiply and restoring divide,
// with a final sign-correction cycle. MTHI/MTLO writes are accepted while idle.
module mult_div_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             hi_write,
   input  logic             lo_write,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t state, next_state;

   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic [WIDTH-1:0] opnd;
   logic [WIDTH-1:0] a_orig;
   logic             is_div;
   logic             neg_q;
   logic             neg_r;
   logic             div_zero;

   logic               signed_op_c;
   logic               a_neg_c;
   logic               b_neg_c;
   logic [WIDTH-1:0]   a_abs_c;
   logic [WIDTH-1:0]   b_abs_c;
   logic [WIDTH:0]     add_sum_c;
   logic [WIDTH:0]     shifted_c;
   logic               sub_ok_c;
   logic [2*WIDTH-1:0] prod_c;
   logic [2*WIDTH-1:0] prod_fix_c;
   logic [WIDTH-1:0]   quo_fix_c;
   logic [WIDTH-1:0]   rem_fix_c;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = CALC;
         CALC:    if (cnt == CNT_W'(WIDTH - 1)) next_state = FIX;
         FIX:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Operand conditioning, per-iteration arithmetic and sign correction
   always_comb begin
      signed_op_c = ~op[0];
      a_neg_c     = signed_op_c & operand_a[WIDTH-1];
      b_neg_c     = signed_op_c & operand_b[WIDTH-1];
      a_abs_c     = a_neg_c ? WIDTH'(-operand_a) : operand_a;
      b_abs_c     = b_neg_c ? WIDTH'(-operand_b) : operand_b;
      add_sum_c   = {1'b0, acc_hi} + {1'b0, opnd};
      shifted_c   = {acc_hi, acc_lo[WIDTH-1]};
      sub_ok_c    = shifted_c >= {1'b0, opnd};
      prod_c      = {acc_hi, acc_lo};
      prod_fix_c  = neg_q ? (2*WIDTH)'(-prod_c) : prod_c;
      quo_fix_c   = neg_q ? WIDTH'(-acc_lo) : acc_lo;
      rem_fix_c   = neg_r ? WIDTH'(-acc_hi) : acc_hi;
   end

   // Datapath and architectural HI/LO
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt      <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         opnd     <= '0;
         a_orig   <= '0;
         is_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  is_div   <= op[1];
                  a_orig   <= operand_a;
                  div_zero <= (operand_b == '0);
                  neg_q    <= a_neg_c ^ b_neg_c;
                  neg_r    <= a_neg_c;
                  cnt      <= '0;
                  busy     <= 1'b1;
                  acc_hi   <= '0;
                  // Divide shifts the dividend out of acc_lo; multiply shifts the multiplier
                  acc_lo   <= op[1] ? a_abs_c : b_abs_c;
                  opnd     <= op[1] ? b_abs_c : a_abs_c;
               end else begin
                  if (hi_write) hi <= operand_a;
                  if (lo_write) lo <= operand_a;
               end
            end
            CALC: begin
               cnt <= cnt + CNT_W'(1);
               if (is_div) begin
                  acc_hi <= sub_ok_c ? WIDTH'(shifted_c - {1'b0, opnd}) : WIDTH'(shifted_c);
                  acc_lo <= {acc_lo[WIDTH-2:0], sub_ok_c};
               end else if (acc_lo[0]) begin
                  {acc_hi, acc_lo} <= {add_sum_c, acc_lo[WIDTH-1:1]};
               end else begin
                  {acc_hi, acc_lo} <= {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
               end
            end
            FIX: begin
               busy <= 1'b0;
               done <= 1'b1;
               if (is_div) begin
                  if (div_zero) begin
                     lo <= '1;
                     hi <= a_orig;
                  end else begin
                     lo <= quo_fix_c;
                     hi <= rem_fix_c;
                  end
               end else begin
                  {hi, lo} <= prod_fix_c;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed ops push expected HI/LO and completion cycle,
// a monitor pops and checks on every done pulse.
module tb_mult_div_unit;

   localparam int unsigned WIDTH = 32;

   typedef struct {
      logic [WIDTH-1:0] hi;
      logic [WIDTH-1:0] lo;
      int unsigned      cyc;
      string            name;
   } exp_t;

   logic             clk;
   logic             reset_n;
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic             hi_write;
   logic             lo_write;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   exp_t        sb_q[$];
   int unsigned cyc;
   int          checks;
   int          errors;
   logic        prev_done;
   logic [WIDTH-1:0] model_hi;
   logic [WIDTH-1:0] model_lo;

   mult_div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .op        (op),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .hi_write  (hi_write),
      .lo_write  (lo_write),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest expected result
   always @(negedge clk) begin
      if (reset_n) begin
         if (done) begin
            check("done_not_back_to_back", 64'(prev_done), 64'd0);
            if (sb_q.size() == 0) begin
               check("unexpected_done", 64'(done), 64'd0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check({e.name, "_hi"}, 64'(hi), 64'(e.hi));
               check({e.name, "_lo"}, 64'(lo), 64'(e.lo));
               check({e.name, "_latency"}, 64'(cyc), 64'(e.cyc));
            end
         end
         prev_done <= done;
      end else begin
         prev_done <= 1'b0;
      end
   end

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (busy) check({name, "_timeout"}, 64'(busy), 64'd0);
   endtask

   // Issue one op; hazard=1 pokes start/hi_write/lo_write and new operands mid-CALC
   task automatic run_op(input string name, input logic [1:0] o, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] eh,
                         input logic [WIDTH-1:0] el, input bit hazard, input bit with_write);
      exp_t e;
      @(negedge clk);
      op        = o;
      operand_a = a;
      operand_b = b;
      start     = 1'b1;
      hi_write  = with_write;
      lo_write  = with_write;
      e.hi   = eh;
      e.lo   = el;
      e.cyc  = cyc + 34;
      e.name = name;
      sb_q.push_back(e);
      @(negedge clk);
      start    = 1'b0;
      hi_write = 1'b0;
      lo_write = 1'b0;
      check({name, "_busy_after_start"}, 64'(busy), 64'd1);
      check({name, "_hi_held"}, 64'(hi), 64'(model_hi));
      check({name, "_lo_held"}, 64'(lo), 64'(model_lo));
      if (hazard) begin
         repeat (4) @(negedge clk);
         start     = 1'b1;
         hi_write  = 1'b1;
         lo_write  = 1'b1;
         op        = 2'b10;
         operand_a = 32'h5555_AAAA;
         operand_b = 32'h0000_0003;
         repeat (3) @(negedge clk);
         start    = 1'b0;
         hi_write = 1'b0;
         lo_write = 1'b0;
         check({name, "_hi_held_calc"}, 64'(hi), 64'(model_hi));
         check({name, "_lo_held_calc"}, 64'(lo), 64'(model_lo));
      end
      wait_idle(name);
      model_hi = eh;
      model_lo = el;
   endtask

   initial begin
      cyc       = 0;
      checks    = 0;
      errors    = 0;
      prev_done = 1'b0;
      model_hi  = '0;
      model_lo  = '0;
      reset_n   = 1'b0;
      start     = 1'b0;
      op        = 2'b00;
      operand_a = 32'hDEAD_BEEF;
      operand_b = 32'hCAFE_F00D;
      hi_write  = 1'b0;
      lo_write  = 1'b0;

      repeat (3) @(negedge clk);
      check("reset_hi", 64'(hi), 64'd0);
      check("reset_lo", 64'(lo), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      reset_n = 1'b1;

      // MTLO alone, then MTHI+MTLO together
      @(negedge clk);
      operand_a = 32'h1234_5678;
      lo_write  = 1'b1;
      @(negedge clk);
      lo_write  = 1'b0;
      check("mtlo_lo", 64'(lo), 64'h1234_5678);
      check("mtlo_hi_untouched", 64'(hi), 64'd0);
      operand_a = 32'hAABB_CCDD;
      hi_write  = 1'b1;
      lo_write  = 1'b1;
      @(negedge clk);
      hi_write  = 1'b0;
      lo_write  = 1'b0;
      check("mthi_both_hi", 64'(hi), 64'hAABB_CCDD);
      check("mthi_both_lo", 64'(lo), 64'hAABB_CCDD);
      model_hi = 32'hAABB_CCDD;
      model_lo = 32'hAABB_CCDD;

      // start with simultaneous writes: writes dropped, HI/LO hold until result
      run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b1);
      run_op("multu", 2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 32'h0000_0004, 32'hFFFF_FFF1, 1'b0, 1'b0);
      run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
      run_op("div_negb", 2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b0);
      run_op("divu", 2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0, 1'b0);
      run_op("divu_zero", 2'b11, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b0, 1'b0);
      run_op("div_zero", 2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0, 1'b0);
      run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);
      run_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0);
      run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
      run_op("multu_hazard", 2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 32'h0000_0004, 32'hFFFF_FFF1, 1'b1, 1'b0);

      // Async reset mid-CALC: no result, no done
      @(negedge clk);
      op        = 2'b01;
      operand_a = 32'h0000_0003;
      operand_b = 32'h0000_0004;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("midreset_busy", 64'(busy), 64'd0);
      check("midreset_done", 64'(done), 64'd0);
      check("midreset_hi", 64'(hi), 64'd0);
      check("midreset_lo", 64'(lo), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (40) @(negedge clk);
      check("midreset_still_idle_busy", 64'(busy), 64'd0);
      check("midreset_hi_after", 64'(hi), 64'd0);

      check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
